// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one pending-writeback counter per architectural register.
// Drives the ID-stage stall when a source is still in flight or the destination counter is saturated.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_ret,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // A simultaneous issue and retire cancel out, so the count is left alone.
  always_ff @(posedge i_clk) begin
    if (!i_rst)               r_cnt <= '0;
    else if (i_inc && !i_ret) r_cnt <= r_cnt + CNT_W'(1);
    else if (i_ret && !i_inc) r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module reg_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 2,
  parameter int WB_BYPASS  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_issue_valid,
  input  logic                          i_issue_wb_en,
  input  logic [REG_ADDR_W-1:0]         i_issue_dest,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_addr,
  input  logic [NUM_SRC-1:0]            i_src_used,
  input  logic                          i_wb_valid,
  input  logic [REG_ADDR_W-1:0]         i_wb_dest,
  output logic                          o_stall,
  output logic [NUM_SRC-1:0]            o_src_pending,
  output logic                          o_dest_full,
  output logic [REG_ADDR_W+CNT_W-1:0]   o_total_pending,
  output logic                          o_idle,
  output logic                          o_err_underflow
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int TOT_W    = REG_ADDR_W + CNT_W;

  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0]               w_dest_cnt;
  logic [CNT_W-1:0]               w_wb_cnt;
  logic                           w_inc;
  logic                           w_ret;
  logic                           w_wb_nz;
  logic                           w_under;
  logic [TOT_W-1:0]               r_total;
  logic                           r_err;

  // $zero is hardwired, so it never holds a pending write.
  assign w_cnt[0] = '0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_reg
      reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_inc && (i_issue_dest == REG_ADDR_W'(r))),
        .i_ret (w_ret && (i_wb_dest == REG_ADDR_W'(r))),
        .o_cnt (w_cnt[r])
      );
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR_W-1:0] w_src;
      logic [CNT_W-1:0]      w_scnt;
      logic                  w_byp;
      assign w_src  = i_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      assign w_scnt = w_cnt[w_src];
      // Last outstanding write landing this cycle is forwarded, so no hazard.
      assign w_byp  = (WB_BYPASS != 0) && i_wb_valid && (i_wb_dest == w_src) &&
                      (w_scnt == CNT_W'(1));
      assign o_src_pending[i] = i_src_used[i] && (w_src != '0) && (w_scnt != '0) && !w_byp;
    end
  endgenerate

  assign w_dest_cnt  = w_cnt[i_issue_dest];
  assign w_wb_cnt    = w_cnt[i_wb_dest];
  // Deliberately ignores a same-cycle retire to the destination.
  assign o_dest_full = i_issue_valid && i_issue_wb_en && (i_issue_dest != '0) &&
                       (w_dest_cnt == {CNT_W{1'b1}});
  assign o_stall     = i_issue_valid && ((|o_src_pending) || o_dest_full);
  assign w_inc       = i_issue_valid && !o_stall && i_issue_wb_en && (i_issue_dest != '0);
  assign w_wb_nz     = i_wb_valid && (i_wb_dest != '0);
  assign w_ret       = w_wb_nz && (w_wb_cnt != '0);
  assign w_under     = w_wb_nz && (w_wb_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_total <= '0;
      r_err   <= 1'b0;
    end else begin
      r_total <= r_total + TOT_W'(w_inc) - TOT_W'(w_ret);
      if (w_under) r_err <= 1'b1;
    end
  end

  assign o_total_pending = r_total;
  assign o_idle          = (r_total == '0);
  assign o_err_underflow = r_err;
endmodule
